mult_accumulate: RTL and testbench

//  Sequential unsigned shift-add multiplier computing p = a*b + c, one multiplier bit per clock.

---
 rtl/mult_pkg.sv | 21 ++
 rtl/mult_if.sv | 26 ++
 rtl/mult_step.sv | 30 +++
 rtl/mult_accumulate.sv | 129 ++++++++++++
 tb/tb_mult_accumulate.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiply-accumulate unit.
// Contents:
//   WIDTH_DEF - default operand width; the product is 2*WIDTH_DEF bits wide
//   state_e   - controller states (IDLE, RUN, DONE), 2-bit encoding
//   cnt_width - width of the step counter for a given operand width
package mult_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One extra bit so the counter can hold WIDTH itself without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mult_if.sv
// Request/result bundle for the multiply-accumulate unit.
// Signals:
//   start   - request; the unit samples it on a rising clock edge while idle
//   a, b, c - multiplicand, multiplier and addend (unsigned)
//   p       - result a*b+c, valid from done onward
//   busy    - high while the operation runs
//   done    - one-cycle pulse marking a fresh p
// Modports: master drives requests, slave is the arithmetic unit.
interface mult_if
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     c;
  logic [2*WIDTH-1:0]   p;
  logic                 busy;
  logic                 done;

  modport master (output start, a, b, c, input p, busy, done);
  modport slave  (input start, a, b, c, output p, busy, done);

endinterface

// File: rtl/mult_step.sv
// One combinational shift-add step of the multiplier.
// Ports:
//   acc, mcand, mplier             - current accumulator, shifted multiplicand, remaining multiplier bits
//   acc_nxt, mcand_nxt, mplier_nxt - values after consuming the multiplier LSB
module mult_step
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic [2*WIDTH-1:0] mcand_nxt,
  output logic [WIDTH-1:0]   mplier_nxt
);

  // Add the multiplicand when the current multiplier bit is set, then advance both operands.
  always_comb begin
    acc_nxt    = acc;
    mcand_nxt  = mcand << 1;
    mplier_nxt = mplier >> 1;
    if (mplier[0]) begin
      acc_nxt = acc + mcand;
    end else begin
      acc_nxt = acc;
    end
  end

endmodule

// File: rtl/mult_accumulate.sv
// Sequential unsigned multiplier computing p = a*b + c, one multiplier bit per clock.
// Rebuilds a dividend from (quotient, divisor, remainder), so it can cross-check divider results.
// Ports:
//   clock   - system clock, rising edge active
//   reset_n - asynchronous active-low reset; discards any operation in flight
//   bus     - mult_if slave: start/a/b/c in, p/busy/done out
// Timing: busy for WIDTH cycles after the accept edge, then done pulses for one cycle.
// The total latency is fixed, and there is no early exit on zero operands.
module mult_accumulate
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic   clock,
  input  logic   reset_n,
  mult_if.slave  bus
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e               state_r;
  state_e               state_nxt_s;
  logic                 accept_s;
  logic                 last_s;

  logic [2*WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [CW-1:0]        cnt_r;
  logic [2*WIDTH-1:0]   p_r;
  logic                 busy_r;
  logic                 done_r;

  logic [2*WIDTH-1:0]   acc_step_s;
  logic [2*WIDTH-1:0]   mcand_step_s;
  logic [WIDTH-1:0]     mplier_step_s;

  mult_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc_r),
    .mcand      (mcand_r),
    .mplier     (mplier_r),
    .acc_nxt    (acc_step_s),
    .mcand_nxt  (mcand_step_s),
    .mplier_nxt (mplier_step_s)
  );

  // Next-state logic: start is level-sensitive in IDLE and ignored elsewhere.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt_s = ST_RUN;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == LAST) begin
          state_nxt_s = ST_DONE;
          last_s      = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture, shift-add iteration and registered result/status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      cnt_r    <= {CW{1'b0}};
      p_r      <= {(2*WIDTH){1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (accept_s) begin
      mcand_r  <= {{WIDTH{1'b0}}, bus.a};
      mplier_r <= bus.b;
      acc_r    <= {{WIDTH{1'b0}}, bus.c};
      cnt_r    <= {CW{1'b0}};
      busy_r   <= 1'b1;
      done_r   <= 1'b0;
    end else if (state_r == ST_RUN) begin
      acc_r    <= acc_step_s;
      mcand_r  <= mcand_step_s;
      mplier_r <= mplier_step_s;
      cnt_r    <= cnt_r + CW'(1);
      if (last_s) begin
        // The final step's sum goes straight to p; acc_r is not needed afterwards.
        p_r    <= acc_step_s;
        done_r <= 1'b1;
        busy_r <= 1'b0;
      end else begin
        done_r <= 1'b0;
        busy_r <= 1'b1;
      end
    end else begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end
  end

  assign bus.p    = p_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_mult_accumulate.sv
// Directed self-checking bench for mult_accumulate: reset values, arithmetic vectors,
// latency/busy timing, ignored mid-run start and reset in the middle of an operation.
module tb_mult_accumulate;
  import mult_pkg::*;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  mult_if #(.WIDTH(32)) bus ();

  mult_accumulate #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one operation; optionally re-pulses start with new operands at cycle glitch_at.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input int glitch_at,
                        output logic [63:0] p_obs, output logic [63:0] p_early,
                        output int lat, output int busy_cycles, output int both);
    @(negedge clock);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.c = c;
    lat = 0;
    busy_cycles = 0;
    both = 0;
    p_early = 64'd0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clock);
      if (n == 1) begin
        bus.start = 1'b0;
        p_early = bus.p;
      end
      if (glitch_at != 0 && n == glitch_at) begin
        bus.start = 1'b1;
        bus.a = 32'd9;
        bus.b = 32'd1;
        bus.c = 32'd3;
      end
      if (glitch_at != 0 && n == glitch_at + 1) bus.start = 1'b0;
      if (bus.busy && bus.done) both++;
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    p_obs = bus.p;
  endtask

  initial begin
    logic [63:0] p_obs;
    logic [63:0] p_early;
    int lat;
    int busy_cycles;
    int both;
    int seen;

    n_checks = 0;
    n_pass = 0;
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    bus.c = 32'd0;
    repeat (3) @(negedge clock);
    check_val("rst_p", bus.p, 64'd0);
    check_val("rst_busy", {63'd0, bus.busy}, 64'd0);
    check_val("rst_done", {63'd0, bus.done}, 64'd0);
    reset_n = 1'b1;

    run_op(32'd13, 32'd2, 32'd0, 0, p_obs, p_early, lat, busy_cycles, both);
    check_val("p_13x2", p_obs, 64'd26);
    check_val("lat_13x2", 64'(lat), 64'd33);
    check_val("busy_cycles", 64'(busy_cycles), 64'd32);
    check_val("busy_done_overlap", 64'(both), 64'd0);
    @(negedge clock);
    check_val("done_one_cycle", {63'd0, bus.done}, 64'd0);

    run_op(32'd84, 32'd3, 32'd2, 0, p_obs, p_early, lat, busy_cycles, both);
    check_val("p_held_at_start", p_early, 64'd26);
    check_val("p_84x3p2", p_obs, 64'd254);
    check_val("lat_84x3p2", 64'(lat), 64'd33);

    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, p_obs, p_early, lat, busy_cycles, both);
    check_val("p_max", p_obs, 64'hFFFFFFFF_00000000);

    run_op(32'd0, 32'd12345, 32'd7, 0, p_obs, p_early, lat, busy_cycles, both);
    check_val("p_zero_a", p_obs, 64'd7);
    check_val("lat_zero_a", 64'(lat), 64'd33);

    run_op(32'd5, 32'd6, 32'd0, 10, p_obs, p_early, lat, busy_cycles, both);
    check_val("p_ignore_restart", p_obs, 64'd30);
    check_val("lat_ignore_restart", 64'(lat), 64'd33);

    // Reset in the middle of a 7*7 operation.
    @(negedge clock);
    bus.start = 1'b1;
    bus.a = 32'd7;
    bus.b = 32'd7;
    bus.c = 32'd0;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (14) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_val("midrst_p", bus.p, 64'd0);
    check_val("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check_val("midrst_done", {63'd0, bus.done}, 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.done || bus.busy) seen = 1;
    end
    check_val("midrst_no_done", 64'(seen), 64'd0);

    run_op(32'd7, 32'd7, 32'd1, 0, p_obs, p_early, lat, busy_cycles, both);
    check_val("p_after_rst", p_obs, 64'd50);
    check_val("lat_after_rst", 64'(lat), 64'd33);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
